// File: rtl/pc_pkg.sv
// pc_pkg: shared select encoding, PC increment and branch-target helper for pc_unit.
//   SEL_*        : 3-bit next-PC source codes driven on pc_unit.sel
//   PC_INCR      : byte distance between sequential instructions
//   branch_target: pc_plus4 + sign-extended word offset, computed at 64 bits
package pc_pkg;

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_JREG   = 3'd3;
    localparam logic [2:0] SEL_EXC    = 3'd4;
    localparam logic [2:0] SEL_RET    = 3'd5;

    localparam int PC_INCR = 4;

    // Callers truncate the result to their own PC width, which gives modulo wrap.
    function automatic logic [63:0] branch_target(input logic [63:0] pc_plus4, input logic [15:0] imm);
        return pc_plus4 + {{46{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clock, reset_n : rising-edge clock, async active-low reset
//   push           : write din at the pointer (overwrites the oldest entry when full)
//   pop            : discard the top entry; with push, replace the top with din instead
//   din            : value to push / replace
//   top            : entry at pointer-1
//   empty, full    : occupancy flags
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;
    logic [PW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign top_idx    = ptr - PW'(1);
    assign top        = mem[top_idx];
    assign empty      = count == '0;
    assign full       = count == (PW+1)'(RAS_DEPTH);
    // A pop on an empty stack is a no-op, including a combined push+pop.
    assign do_push    = push && !pop;
    assign do_pop     = pop && !push && !empty;
    assign do_replace = pop && push && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= do_push ? ptr + PW'(1) : do_pop ? top_idx : ptr;
            count <= (do_push && !full) ? count + 1'b1 : do_pop ? count - 1'b1 : count;
        end
    end

    // Storage needs no reset: top is only consumed when count is nonzero.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[ptr] <= din;
        else if (do_replace)
            mem[top_idx] <= din;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with internal next-PC selection, alignment check and RAS.
//   clock, reset_n : rising-edge clock, async active-low reset
//   stall          : hold all state this cycle
//   sel            : next-PC source (SEQ/BRANCH/JUMP/JREG/EXC/RET; 6,7 act as SEQ)
//   branch_taken   : qualifies BRANCH
//   imm            : signed branch offset in words
//   jtarget        : jump target field
//   reg_target     : JREG target and RET fallback when the RAS is empty
//   push           : push pc_plus4 onto the RAS
//   pc, pc_plus4   : registered PC and its combinational successor
//   epc            : PC of the last excepting / misaligned-redirecting instruction
//   misaligned     : set for the cycle following a misaligned redirect
//   ras_empty/full : RAS occupancy
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0040_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [2:0]       sel,
    input  logic             branch_taken,
    input  logic [15:0]      imm,
    input  logic [25:0]      jtarget,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             push,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             misaligned,
    output logic             ras_empty,
    output logic             ras_full
);
    logic [2:0]       sel_eff;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] jump_dest;
    logic [WIDTH-1:0] branch_dest;
    logic [WIDTH-1:0] cand;
    logic             is_exc;
    logic             bad;
    logic             ras_push;
    logic             ras_pop;

    assign sel_eff     = (sel > SEL_RET) ? SEL_SEQ : sel;
    assign pc_plus4    = pc + WIDTH'(PC_INCR);
    // Keep the region bits above 28 from pc_plus4, splice in the word target.
    assign jump_dest   = (pc_plus4 & ~WIDTH'(28'hFFF_FFFF)) | WIDTH'({jtarget, 2'b00});
    assign branch_dest = WIDTH'(branch_target(64'(pc_plus4), imm));
    assign is_exc      = sel_eff == SEL_EXC;

    always_comb begin
        cand = pc_plus4;
        cand = (sel_eff == SEL_BRANCH && branch_taken) ? branch_dest :
               (sel_eff == SEL_JUMP)                   ? jump_dest   :
               (sel_eff == SEL_JREG)                   ? reg_target  :
               is_exc                                  ? EXC_VECTOR  :
               (sel_eff == SEL_RET)                    ? (ras_empty ? reg_target : ras_top) :
                                                         pc_plus4;
    end

    assign bad = (cand[1:0] != 2'b00) && !is_exc;

    // Faulting redirects leave the RAS untouched; EXC also drops a link push.
    assign ras_push = push && !stall && !bad && !is_exc;
    assign ras_pop  = (sel_eff == SEL_RET) && !stall && !bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_VECTOR;
            epc        <= '0;
            misaligned <= 1'b0;
        end else if (!stall) begin
            pc         <= (is_exc || bad) ? EXC_VECTOR : cand;
            epc        <= (is_exc || bad) ? pc : epc;
            misaligned <= bad;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (ras_push),
        .pop     (ras_pop),
        .din     (pc_plus4),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full)
    );

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the MIPS core; replaces the bare clocked PC register.
- Holds the PC and computes next-PC internally from a select code: sequential, branch, jump, jump-register, exception and return.
- Adds async reset to a vector, stall hold, alignment checking with EPC capture, and a small return-address stack (RAS) for call/return.
- Feeds instruction memory and the IF/ID pipeline register.

Parameters:
WIDTH, 32, PC width in bits (≥28)
RESET_VECTOR, 32'h0040_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception or misaligned target
RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and all state this cycle
sel  in  3  next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 EXC, 5 RET; 6 and 7 treated as SEQ
branch_taken  in  1  qualifies BRANCH
imm  in  16  branch offset in words, signed
jtarget  in  26  jump target field
reg_target  in  WIDTH  register value for JREG, and RET fallback
push  in  1  link: push pc_plus4 onto RAS this cycle
pc  out  WIDTH  current PC (registered)
pc_plus4  out  WIDTH  pc+4, combinational
epc  out  WIDTH  PC of last faulting/excepted instruction
misaligned  out  1  registered; set in the cycle after a misaligned redirect
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_VECTOR, epc=0, misaligned=0.
  - RAS count=0, pointer=0; ras_empty=1, ras_full=0.
  - Reset asserted mid-operation overrides everything immediately.
- Update rule: all state updates on the rising clock edge when reset_n=1.
- Stall: stall=1 holds pc, epc, misaligned and the RAS unchanged; push and sel are ignored.
- Candidate target (when stall=0):
  - SEQ: pc+4.
  - BRANCH: pc+4+(sext(imm)<<2) if branch_taken, else pc+4.
  - JUMP: {pc_plus4[WIDTH-1:28], jtarget, 2'b00}.
  - JREG: reg_target.
  - EXC: EXC_VECTOR.
  - RET: RAS top if not empty, else reg_target.
- Arithmetic: all adds are modulo 2^WIDTH; wrap-around is silent.
- Alignment check: if the candidate has bits[1:0]≠0 and sel≠EXC, then pc<=EXC_VECTOR, epc<=pc, misaligned<=1. Otherwise misaligned<=0.
- EXC: pc<=EXC_VECTOR, epc<=pc.
- Latency: new pc is visible one cycle after sel is sampled. pc_plus4 follows pc combinationally.
- RAS is a circular buffer; ras_top always reflects the entry at pointer-1.
  - push only (not RET): write pc_plus4, pointer+1, count+1 saturating at RAS_DEPTH.
  - push when full: overwrite the oldest entry; ras_full stays 1.
  - RET without push, not empty: pointer-1, count-1.
  - RET with push: replace the top entry with pc_plus4; count unchanged.
  - RET when empty: no RAS change; the reg_target fallback is used.
- RAS on faults: a misaligned redirect suppresses any RAS push or pop that cycle. EXC with push also suppresses the push.

Decomposition:
- Package pc_pkg holds:
  - sel encoding localparams SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JREG, SEL_EXC, SEL_RET;
  - a PC_INCR=4 constant;
  - a function for branch target computation.
- One sub-module: pc_ras, parametrised by WIDTH and RAS_DEPTH.
  - Ports: push, pop, din, top, empty, full.

Test Plan:
- Reset then 3 cycles SEQ -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- BRANCH, taken, imm=16'hFFFF at pc=0x00400010 -> pc=0x00400010. Same with branch_taken=0 -> pc=0x00400014.
- JUMP jtarget=26'h0000100 at pc=0x00400000 -> pc=0x00000400. JREG reg_target=0x00400022 -> pc=0x80000180, epc=old pc, misaligned=1 for one cycle.
- Stall held 2 cycles during JUMP -> pc unchanged, then jumps on the first unstalled edge.
- Four pushes at pc A..D, then a fifth push at E -> ras_full=1. Five RETs -> E, D, C, B, then reg_target (empty fallback), with ras_empty=1 after the fourth.
- reset_n pulsed low mid-cycle during RET -> pc=RESET_VECTOR immediately and RAS empty.
